// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the serial sequence detector.
// A one-word hold buffer lets back-to-back words stream with no idle bit between them.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_hold_full;
    logic             w_hold_full_nxt;

    logic             w_accept;
    logic             w_last;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;

    // rst gates load_ready so nothing can be accepted while reset is held
    assign load_ready = rst & ~r_hold_full;
    assign w_accept   = load_valid & load_ready;
    assign w_last     = (r_cnt == LAST);

    assign w_out_bit  = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign w_shifted  = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);

    assign out_valid   = (r_state == SHIFT);
    assign out         = (r_state == SHIFT) & w_out_bit;
    assign frame_start = (r_state == SHIFT) & (r_cnt == '0);
    assign busy        = (r_state == SHIFT) | r_hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_hold      <= w_hold_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_hold_nxt      = r_hold;
        w_cnt_nxt       = r_cnt;
        w_hold_full_nxt = r_hold_full;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sreg_nxt  = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_sreg_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (w_accept) begin
                        w_hold_nxt      = data_in;
                        w_hold_full_nxt = 1'b1;
                    end
                // Last bit: a held word wins over a fresh one (load_ready is low then anyway)
                end else if (r_hold_full) begin
                    w_sreg_nxt      = r_hold;
                    w_cnt_nxt       = '0;
                    w_hold_full_nxt = 1'b0;
                end else if (w_accept) begin
                    w_sreg_nxt = data_in;
                    w_cnt_nxt  = '0;
                end else begin
                    w_sreg_nxt  = w_shifted;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a word-level model of the stream.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;

    logic m_ready, m_out, m_valid, m_frame, m_busy;
    logic l_ready, l_out, l_valid, l_frame, l_busy;

    int n_total = 0;
    int n_bad   = 0;

    // Model: the word currently on the wire, which bit of it is showing, and words waiting.
    logic [W-1:0] mdl_cur = '0;
    int           mdl_idx = 0;
    bit           mdl_act = 1'b0;
    logic [W-1:0] mdl_pend[$];

    // Serial stream seen by the MSB-first instance, for the 1011 pattern count.
    logic [3:0] win = '0;
    int         hits = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(m_ready), .out(m_out), .out_valid(m_valid),
        .frame_start(m_frame), .busy(m_busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(l_ready), .out(l_out), .out_valid(l_valid),
        .frame_start(l_frame), .busy(l_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_cur = '0;
        mdl_idx = 0;
        mdl_act = 1'b0;
        mdl_pend.delete();
        win = '0;
    endtask

    // One rising edge as seen by the model, using the inputs the DUT samples at that edge.
    task automatic model_edge();
        bit acc;
        acc = load_valid && (mdl_pend.size() == 0);
        if (mdl_act) begin
            win = {win[2:0], mdl_cur[W-1-mdl_idx]};
            if (win == 4'b1011) hits++;
            mdl_idx++;
            if (mdl_idx == W) mdl_act = 1'b0;
        end else begin
            win = {win[2:0], 1'b0};
        end
        if (acc) mdl_pend.push_back(data_in);
        if (!mdl_act && mdl_pend.size() > 0) begin
            mdl_cur = mdl_pend.pop_front();
            mdl_idx = 0;
            mdl_act = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic e_msb, e_lsb;
        e_msb = mdl_act ? mdl_cur[W-1-mdl_idx] : 1'b0;
        e_lsb = mdl_act ? mdl_cur[mdl_idx] : 1'b0;
        check_val("out_msb",   32'(m_out),   32'(e_msb));
        check_val("out_lsb",   32'(l_out),   32'(e_lsb));
        check_val("valid",     32'(m_valid), 32'(mdl_act));
        check_val("valid_lsb", 32'(l_valid), 32'(mdl_act));
        check_val("frame",     32'(m_frame), 32'(mdl_act && mdl_idx == 0));
        check_val("frame_lsb", 32'(l_frame), 32'(mdl_act && mdl_idx == 0));
        check_val("busy",      32'(m_busy),  32'(mdl_act || mdl_pend.size() > 0));
        check_val("ready",     32'(m_ready), 32'(mdl_pend.size() == 0));
        check_val("ready_lsb", 32'(l_ready), 32'(mdl_pend.size() == 0));
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input logic lv, input logic [W-1:0] d);
        load_valid = lv;
        data_in    = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_in_reset(input string tag);
        check_val({tag, "_out"},   32'({m_out, l_out}),     32'(0));
        check_val({tag, "_valid"}, 32'({m_valid, l_valid}), 32'(0));
        check_val({tag, "_frame"}, 32'({m_frame, l_frame}), 32'(0));
        check_val({tag, "_busy"},  32'({m_busy, l_busy}),   32'(0));
        check_val({tag, "_ready"}, 32'({m_ready, l_ready}), 32'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        int h0;
        // Reset held across a few edges with load_valid asserted
        load_valid = 1'b1;
        data_in    = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_in_reset("rst0");
        load_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1 check_outputs();

        // Quiet period: nothing valid, zeros on the wire
        idle(10);

        // Single word B0 (LSB instance sees 0D-style ordering of B0), one 1011 hit
        h0 = hits;
        step(1'b1, 8'hB0);
        idle(10);
        check_val("b0_hits", 32'(hits - h0), 32'(1));

        // LSB-first 0D gives 1,0,1,1 on the LSB instance
        step(1'b1, 8'h0D);
        idle(9);

        // Back-to-back A5, 3C with load_valid held; second word waits in hold
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        check_val("hold_ready", 32'(m_ready), 32'(0));
        for (int i = 0; i < 6; i++) step(1'b1, W'($urandom));
        step(1'b0, 8'h00);
        idle(18);

        // 01 then 60: 1011 only exists across the word boundary
        h0 = hits;
        step(1'b1, 8'h01);
        step(1'b1, 8'h60);
        idle(20);
        check_val("bnd_hits", 32'(hits - h0), 32'(1));

        // Async reset between edges at bit 4 with a word in hold
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check_val("pre_rst_hold", 32'(m_ready), 32'(0));
        #2 rst = 1'b0;
        #1 check_in_reset("arst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        step(1'b1, 8'hC3);
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
